// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - four-digit FND scan controller sharing one BCD-to-FND decoder
// Optional leading-zero blanking is compiled in with `define FND_LZ_BLANK_EN.
module fnd_scan_controller #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
  input  logic        i_load,
  input  logic        i_lz_en,
  output logic [3:0]  o_dec_value,
  output logic        o_dec_en,
  output logic [3:0]  o_fnd_com,
  output logic        o_frame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {GAP, SHOW} state_t;

  state_t        state_q, state_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    value_q, value_d;
  logic          en_q, en_d;
  logic [3:0]    com_q, com_d;
  logic          frame_q, frame_d;

  logic [3:0]    cur_nib;
  logic          blank;

  assign cur_nib = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef FND_LZ_BLANK_EN
  logic [15:0] upper_digits;
  assign upper_digits = shadow_q >> {idx_q, 2'b00};
  // Digit 0 always shows so an all-zero result still reads "0".
  assign blank = i_lz_en && (idx_q != 2'd0) && (upper_digits == 16'h0000);
`else
  logic unused_lz_en;
  assign unused_lz_en = i_lz_en;
  assign blank        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    en_d     = en_q;
    com_d    = com_q;
    shadow_d = i_load ? i_bcd : shadow_q;

    case (state_q)
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d = SHOW;
          value_d = cur_nib;
          en_d    = blank;
          com_d   = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        end
      end
      SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          en_d    = 1'b1;
          com_d   = 4'b1111;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = GAP;
      end
    endcase

    // Registered so it lands exactly on the last SHOW cycle of digit 3.
    frame_d = (state_d == SHOW) && (idx_d == 2'd3) && (cnt_d == SLOT_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= GAP;
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      en_q     <= 1'b1;
      com_q    <= 4'b1111;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      en_q     <= en_d;
      com_q    <= com_d;
      frame_q  <= frame_d;
    end
  end

  assign o_dec_value = value_q;
  assign o_dec_en    = en_q;
  assign o_fnd_com   = com_q;
  assign o_frame     = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - randomized check of fnd_scan_controller against a time-indexed slot model
module tb_fnd_scan_controller;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        i_reset, i_load, i_lz_en;
  logic [15:0] i_bcd;
  logic [3:0]  o_dec_value, o_fnd_com;
  logic        o_dec_en, o_frame;

  always #5 clk = ~clk;

  fnd_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_bcd      (i_bcd),
    .i_load     (i_load),
    .i_lz_en    (i_lz_en),
    .o_dec_value(o_dec_value),
    .o_dec_en   (o_dec_en),
    .o_fnd_com  (o_fnd_com),
    .o_frame    (o_frame)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: t = cycles since reset; slot position and digit follow from t alone.
  int          t;
  logic [15:0] m_sh;
  logic [3:0]  m_val, m_com;
  logic        m_en, m_frame;

  task automatic model_edge();
    int p, d;
    logic blk;
    if (i_reset) begin
      t = 0; m_sh = 16'h0; m_val = 4'h0; m_en = 1'b1; m_com = 4'hF; m_frame = 1'b0;
    end else begin
      p = t % SD;
      d = (t / SD) % 4;
      if (p == BC - 1) begin
        blk = 1'b0;
`ifdef FND_LZ_BLANK_EN
        blk = i_lz_en && (d != 0) && ((m_sh >> (4 * d)) == 16'h0);
`endif
        m_val = 4'((m_sh >> (4 * d)) & 16'hF);
        m_en  = blk;
        m_com = blk ? 4'hF : ~(4'(1 << d));
      end
      if (p == SD - 1) begin
        m_en  = 1'b1;
        m_com = 4'hF;
      end
      t = t + 1;
      m_frame = ((t % SD) == SD - 1) && (((t / SD) % 4) == 3);
      if (i_load) m_sh = i_bcd;
    end
  endtask

  task automatic check_outputs();
    chk_eq("com",   o_fnd_com, m_com);
    chk_eq("en",    o_dec_en, m_en);
    chk_eq("value", o_dec_value, m_val);
    chk_eq("frame", o_frame, m_frame);
    chk_eq("one_com_low", ($countones(~o_fnd_com) <= 1), 1);
  endtask

  task automatic cycle(input logic r, input logic l, input logic [15:0] b, input logic z);
    i_reset = r; i_load = l; i_bcd = b; i_lz_en = z;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [15:0] pick_bcd();
    case ($urandom_range(0, 5))
      0: return 16'h1234;
      1: return 16'h5678;
      2: return 16'h00A0;
      3: return 16'h0040;
      4: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic r, l, z;
    i_reset = 1'b1; i_load = 1'b0; i_bcd = 16'h0; i_lz_en = 1'b0;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0);
    chk_eq("rst_com",   o_fnd_com, 4'hF);
    chk_eq("rst_en",    o_dec_en, 1'b1);
    chk_eq("rst_value", o_dec_value, 4'h0);

    // Load 1234 and free-run three frames.
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    repeat (3 * 4 * SD) cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // Mid-SHOW load on digit 1 (t = 12 after this resync).
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    repeat (11) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h5678, 1'b0);
    repeat (2 * 4 * SD) cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // Reset during digit 2 SHOW.
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h00A0, 1'b0);
    repeat (18) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 16'h9999, 1'b0);
    chk_eq("midrst_com",   o_fnd_com, 4'hF);
    chk_eq("midrst_en",    o_dec_en, 1'b1);
    chk_eq("midrst_value", o_dec_value, 4'h0);
    repeat (4 * SD) cycle(1'b0, 1'b0, 16'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 9) == 0);
      z = ($urandom_range(0, 3) != 0);
      cycle(r, l, pick_bcd(), z);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
